// File: rtl/stopwatch_timer_if.sv
// Control/display bundle for stopwatch_timer: pulse controls and preset in, ASCII display and status out.
interface stopwatch_timer_if;
  logic        start;
  logic        stop;
  logic        clear;
  logic        load;
  logic        lap;
  logic        mode;
  logic [6:0]  preset_min;
  logic [5:0]  preset_sec;
  logic [63:0] disp_vec;
  logic        running;
  logic        expired;
  logic        lap_hold;

  modport master (
    output start, stop, clear, load, lap, mode, preset_min, preset_sec,
    input  disp_vec, running, expired, lap_hold
  );

  modport slave (
    input  start, stop, clear, load, lap, mode, preset_min, preset_sec,
    output disp_vec, running, expired, lap_hold
  );
endinterface

// File: rtl/stopwatch_timer.sv
// Stopwatch / countdown timer on six BCD digits with a 1/100 s prescaled tick and ASCII "MM:SS.hh" output.
// Latency: disp_vec is registered, 1 clk after a digit change; no backpressure, controls are single-cycle pulses.
module stopwatch_timer #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned MAX_MIN = 99
) (
  input  logic              clk,
  input  logic              rst_n,
  stopwatch_timer_if.slave  bus
);

  localparam int unsigned   TICK_CLKS = CLK_HZ / 100;
  localparam int unsigned   PW        = $clog2(TICK_CLKS);
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_CLKS - 1);
  localparam logic [6:0]    MAX_MIN_B = 7'(MAX_MIN);
  localparam logic [3:0]    MAX_T     = 4'(MAX_MIN / 10);
  localparam logic [3:0]    MAX_O     = 4'(MAX_MIN % 10);
  localparam logic [63:0]   DISP_RST  = 64'h30303A30302E3030;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  typedef struct packed {
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
    logic [3:0] h1;
    logic [3:0] h0;
  } bcd_time_t;

  localparam bcd_time_t TIME_MAX = {MAX_T, MAX_O, 4'd5, 4'd9, 4'd9, 4'd9};

  function automatic bcd_time_t bcd_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.h0 != 4'd9) r.h0 = t.h0 + 4'd1;
    else begin
      r.h0 = 4'd0;
      if (t.h1 != 4'd9) r.h1 = t.h1 + 4'd1;
      else begin
        r.h1 = 4'd0;
        if (t.s0 != 4'd9) r.s0 = t.s0 + 4'd1;
        else begin
          r.s0 = 4'd0;
          if (t.s1 != 4'd5) r.s1 = t.s1 + 4'd1;
          else begin
            r.s1 = 4'd0;
            if (t.m0 != 4'd9) r.m0 = t.m0 + 4'd1;
            else begin
              r.m0 = 4'd0;
              r.m1 = t.m1 + 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.h0 != 4'd0) r.h0 = t.h0 - 4'd1;
    else begin
      r.h0 = 4'd9;
      if (t.h1 != 4'd0) r.h1 = t.h1 - 4'd1;
      else begin
        r.h1 = 4'd9;
        if (t.s0 != 4'd0) r.s0 = t.s0 - 4'd1;
        else begin
          r.s0 = 4'd9;
          if (t.s1 != 4'd0) r.s1 = t.s1 - 4'd1;
          else begin
            r.s1 = 4'd5;
            if (t.m0 != 4'd0) r.m0 = t.m0 - 4'd1;
            else begin
              r.m0 = 4'd9;
              r.m1 = t.m1 - 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  // Preset values are at most 99, so nine conditional subtractions of ten are enough.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [6:0] rem;
    logic [3:0] tens;
    rem  = v;
    tens = 4'd0;
    for (int k = 0; k < 9; k++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  function automatic logic [63:0] to_ascii(input bcd_time_t t);
    return {4'h3, t.m1, 4'h3, t.m0, 8'h3A, 4'h3, t.s1, 4'h3, t.s0,
            8'h2E, 4'h3, t.h1, 4'h3, t.h0};
  endfunction

  state_t    r_state, w_state_nxt;
  bcd_time_t r_time, w_time_nxt;
  bcd_time_t r_snap, w_snap_nxt;
  logic [PW-1:0] r_pre, w_pre_nxt;
  logic      r_dmode, w_dmode_nxt;
  logic      r_hold, w_hold_nxt;
  logic      r_expired, w_exp_nxt;
  logic [63:0] r_disp;

  bcd_time_t  w_inc, w_dec, w_preset;
  logic [6:0] w_pmin;
  logic [5:0] w_psec;
  logic [7:0] w_pmin_bcd, w_psec_bcd;
  logic       w_count, w_tick, w_at_max;

  assign w_inc      = bcd_inc(r_time);
  assign w_dec      = bcd_dec(r_time);
  assign w_at_max   = (r_time == TIME_MAX);
  assign w_pmin     = (bus.preset_min > MAX_MIN_B) ? MAX_MIN_B : bus.preset_min;
  assign w_psec     = (bus.preset_sec > 6'd59) ? 6'd59 : bus.preset_sec;
  assign w_pmin_bcd = to_bcd(w_pmin);
  assign w_psec_bcd = to_bcd({1'b0, w_psec});
  assign w_preset   = {w_pmin_bcd, w_psec_bcd, 8'h00};
  // The prescaler advances on every RUN cycle, including the one carrying stop.
  assign w_count    = (r_state == S_RUN) && !bus.clear && !bus.load;
  assign w_tick     = w_count && (r_pre == PRE_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_time_nxt  = r_time;
    w_snap_nxt  = r_snap;
    w_pre_nxt   = r_pre;
    w_dmode_nxt = r_dmode;
    w_hold_nxt  = r_hold;
    w_exp_nxt   = 1'b0;

    if (bus.clear) begin
      w_state_nxt = S_IDLE;
      w_time_nxt  = '0;
      w_hold_nxt  = 1'b0;
    end else if (bus.load) begin
      w_state_nxt = S_IDLE;
      w_time_nxt  = w_preset;
      w_hold_nxt  = 1'b0;
    end else if (bus.stop) begin
      if (r_state == S_RUN) w_state_nxt = S_PAUSE;
    end else if (bus.start) begin
      if (r_state == S_IDLE && !(bus.mode && r_time == '0)) begin
        w_state_nxt = S_RUN;
        w_dmode_nxt = bus.mode;
        w_pre_nxt   = '0;
      end else if (r_state == S_PAUSE) begin
        w_state_nxt = S_RUN;
      end
    end else if (bus.lap) begin
      if (r_hold) w_hold_nxt = 1'b0;
      else if (r_state == S_RUN || r_state == S_PAUSE) begin
        w_snap_nxt = r_time;
        w_hold_nxt = 1'b1;
      end
    end

    // Reaching the end of the count overrides a same-cycle stop.
    if (w_count) begin
      if (w_tick) begin
        w_pre_nxt = '0;
        if (!r_dmode) begin
          if (w_at_max) begin
            w_state_nxt = S_DONE;
            w_exp_nxt   = 1'b1;
          end else begin
            w_time_nxt = w_inc;
          end
        end else begin
          w_time_nxt = w_dec;
          if (w_dec == '0) begin
            w_state_nxt = S_DONE;
            w_exp_nxt   = 1'b1;
          end
        end
      end else begin
        w_pre_nxt = r_pre + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_time    <= '0;
      r_snap    <= '0;
      r_pre     <= '0;
      r_dmode   <= 1'b0;
      r_hold    <= 1'b0;
      r_expired <= 1'b0;
      r_disp    <= DISP_RST;
    end else begin
      r_state   <= w_state_nxt;
      r_time    <= w_time_nxt;
      r_snap    <= w_snap_nxt;
      r_pre     <= w_pre_nxt;
      r_dmode   <= w_dmode_nxt;
      r_hold    <= w_hold_nxt;
      r_expired <= w_exp_nxt;
      r_disp    <= to_ascii(r_hold ? r_snap : r_time);
    end
  end

  assign bus.disp_vec = r_disp;
  assign bus.running  = (r_state == S_RUN);
  assign bus.expired  = r_expired;
  assign bus.lap_hold = r_hold;

endmodule
